// File: rtl/smart_clock_pkg.sv
// Encodings and constants shared between the clock pipeline stages and the display driver.
// Segment patterns use the active-high {g,f,e,d,c,b,a} form.
package smart_clock_pkg;

  localparam logic [1:0] CONF_RUN  = 2'b00;
  localparam logic [1:0] CONF_HOUR = 2'b01;
  localparam logic [1:0] CONF_MIN  = 2'b10;
  localparam logic [1:0] CONF_SEC  = 2'b11;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 16;
  localparam int MIN_MSB  = 15;
  localparam int MIN_LSB  = 8;
  localparam int SEC_MSB  = 7;
  localparam int SEC_LSB  = 0;

  localparam logic [7:0] HOUR_MAX   = 8'd23;
  localparam logic [7:0] MINSEC_MAX = 8'd59;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic       dash;
    logic [3:0] val;
  } digit_t;

  // Tens/units split by compare-and-subtract; only meaningful for v <= 59,
  // larger values are shown as dashes before this result is used.
  function automatic logic [7:0] split_bcd(input logic [7:0] v);
    logic [3:0] t;
    logic [7:0] r;
    t = 4'd0;
    r = v;
    if (r >= 8'd50) begin
      t = 4'd5; r = r - 8'd50;
    end else if (r >= 8'd40) begin
      t = 4'd4; r = r - 8'd40;
    end else if (r >= 8'd30) begin
      t = 4'd3; r = r - 8'd30;
    end else if (r >= 8'd20) begin
      t = 4'd2; r = r - 8'd20;
    end else if (r >= 8'd10) begin
      t = 4'd1; r = r - 8'd10;
    end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single digit to active-high 7-segment pattern; the dash flag overrides the digit.
module seg7_decode
  import smart_clock_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (dash)
      seg = SEG_DASH;
    else if (digit < 4'd10)
      seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed HH.MM.SS display driver with per-frame snapshot,
// ghost-suppression gap, range dashes and blinking of the field being set.
module seg7_scan_driver
  import smart_clock_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] screen_time,
  input  logic [1:0]  conf_stat,
  output logic [5:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [SW-1:0] scan_cnt, scan_nxt;
  logic [2:0]    digit_idx, idx_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          blink_on, on_nxt;
  logic [23:0]   snap, snap_nxt;
  logic [1:0]    conf_q;
  logic          fresh;

  logic          scan_tc;
  logic [1:0]    field;
  logic [7:0]    fval;
  logic [7:0]    bcd;
  digit_t        dig;
  logic [6:0]    seg_hi;
  logic          blank;
  logic [5:0]    sel_val;
  logic [6:0]    seg_val;
  logic          dp_val;

  always_comb begin
    scan_tc  = (scan_cnt == SW'(SCAN_DIV - 1));
    scan_nxt = scan_tc ? '0 : scan_cnt + SW'(1);
    idx_nxt  = digit_idx;
    if (scan_tc)
      idx_nxt = (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    snap_nxt = (fresh || (scan_tc && digit_idx == 3'd5)) ? screen_time : snap;

    // A conf_stat change restarts the blink phase so the new field shows at once.
    if (conf_stat != conf_q) begin
      blink_nxt = '0;
      on_nxt    = 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_nxt = '0;
      on_nxt    = ~blink_on;
    end else begin
      blink_nxt = blink_cnt + BW'(1);
      on_nxt    = blink_on;
    end
  end

  // Output values are derived from next state so the registered pins line up
  // with the counters and snapshot they were computed from.
  always_comb begin
    field = idx_nxt[2:1];
    fval  = snap_nxt[SEC_MSB:SEC_LSB];
    dig.dash = snap_nxt[SEC_MSB:SEC_LSB] > MINSEC_MAX;
    if (field == 2'd0) begin
      fval     = snap_nxt[HOUR_MSB:HOUR_LSB];
      dig.dash = snap_nxt[HOUR_MSB:HOUR_LSB] > HOUR_MAX;
    end else if (field == 2'd1) begin
      fval     = snap_nxt[MIN_MSB:MIN_LSB];
      dig.dash = snap_nxt[MIN_MSB:MIN_LSB] > MINSEC_MAX;
    end
    bcd     = split_bcd(fval);
    dig.val = idx_nxt[0] ? bcd[3:0] : bcd[7:4];

    blank   = (conf_stat != CONF_RUN) && (field == conf_stat - 2'd1) && !on_nxt;
    sel_val = (scan_nxt == '0) ? 6'd0 : (6'b1 << idx_nxt);
    seg_val = blank ? SEG_OFF : seg_hi;
    dp_val  = !blank && (idx_nxt == 3'd1 || idx_nxt == 3'd3);
  end

  seg7_decode u_decode (
    .digit (dig.val),
    .dash  (dig.dash),
    .seg   (seg_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      snap      <= 24'd0;
      conf_q    <= CONF_RUN;
      fresh     <= 1'b1;
      digit_sel <= {6{ACTIVE_LOW}};
      seg       <= {7{ACTIVE_LOW}};
      dp        <= ACTIVE_LOW;
    end else begin
      scan_cnt  <= scan_nxt;
      digit_idx <= idx_nxt;
      blink_cnt <= blink_nxt;
      blink_on  <= on_nxt;
      snap      <= snap_nxt;
      conf_q    <= conf_stat;
      fresh     <= 1'b0;
      digit_sel <= ACTIVE_LOW ? ~sel_val : sel_val;
      seg       <= ACTIVE_LOW ? ~seg_val : seg_val;
      dp        <= ACTIVE_LOW ? ~dp_val : dp_val;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes `screen_time` (8-bit binary hour/minute/second fields) from the screen stage and drives a 6-digit multiplexed 7-segment display showing HH.MM.SS.
- Converts each field to two decimal digits and scans one digit at a time.
- During configuration, blinks the field selected by `conf_stat`.
- Sits between the screen stage and the board pins.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit is enabled (including its blanking cycle); minimum 2.
- BLINK_DIV, 500000: clk cycles per blink half-period; minimum 2.
- ACTIVE_LOW, 1: 1 means `seg`, `dp` and `digit_sel` drive low to light; 0 means drive high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- screen_time  in  24  [23:16] hour, [15:8] minute, [7:0] second, binary.
- conf_stat  in  2  00 run, 01 set hour, 10 set minute, 11 set second.
- digit_sel  out  6  one-hot digit enable; bit0 = hour tens (leftmost), bit5 = second units.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point; lit on digits 1 and 3 (separators).

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - `digit_sel` all inactive, `seg` all off, `dp` off (polarity per ACTIVE_LOW).
  - scan_cnt = 0, digit_idx = 0, blink_cnt = 0, blink_on = 1, snapshot = 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, digit_idx advances 0→1→…→5→0.
- Ghost suppression: during the cycle with scan_cnt == 0, `digit_sel` is all inactive. For scan_cnt ≥ 1 the selected digit is enabled.
- Snapshot:
  - `screen_time` is latched into snap when digit_idx wraps 5→0, and on the first clk edge after rst deasserts.
  - All six digits of one frame come from one snapshot; no tearing.
- Digit decode per field value v:
  - tens = v / 10, units = v % 10, computed from snap by compare/subtract. No divider.
  - Leading zero is shown: hour 7 displays "07".
- Range check:
  - Hour > 23, or minute/second > 59, displays both digits of that field as dash (segment g only).
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1.
  - At terminal count, blink_on toggles.
- Blink field selection:
  - With conf_stat != 00, the digits of the selected field show `seg` off and `dp` off while blink_on = 0. `digit_sel` still scans.
  - conf_stat 00: no blanking.
- Blink restart on change:
  - Any change of conf_stat, sampled with a registered copy, forces blink_cnt = 0 and blink_on = 1 on the next edge, so the newly selected field is visible immediately.
  - This restart takes priority over the terminal-count toggle in the same cycle.
- Latency: a `screen_time` change appears no later than the next frame start plus 1 cycle, bounded by 6·SCAN_DIV+1 cycles.
- Reset mid-scan: outputs go inactive immediately (async). Scanning restarts at digit 0 with a fresh snapshot.
- `dp` follows `seg` blanking rules and the ACTIVE_LOW polarity.

Decomposition:
- Shared package smart_clock_pkg:
  - conf_stat encodings CONF_RUN=2'b00, CONF_HOUR=2'b01, CONF_MIN=2'b10, CONF_SEC=2'b11.
  - Field bit ranges HOUR_MSB/LSB, MIN_MSB/LSB, SEC_MSB/LSB.
  - Max values HOUR_MAX=23, MINSEC_MAX=59.
  - Segment constants SEG_DIGIT[0..9], SEG_DASH, SEG_OFF (active-high form).
- One combinational sub-module, seg7_decode: 4-bit digit plus a dash flag in, 7-bit active-high segments out.
- Polarity inversion is applied once at the output registers.

Test Plan (SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=0):
- rst held, then released with screen_time=24'h0C_22_05 (12:34:05) → outputs all 0 during reset; frame shows digits 1,2,3,4,0,5 → seg 0x06,0x5B,0x4F,0x66,0x3F,0x6D; dp=1 on digits 1 and 3; digit_sel 000001..100000, each one-hot for 3 cycles after a 1-cycle all-zero gap.
- Change screen_time to 24'h17_3B_3B (23:59:59) mid-frame (digit 2) → remainder of frame still shows 12:34:05; next frame shows 2,3,5,9,5,9.
- screen_time minute field = 8'd60, hour = 8'd24 → hour and minute digits show 0x40 (dash); seconds decode normally.
- conf_stat=01 → hour digits blank (seg=0, dp=0) for 16-cycle windows alternating with visible ones. Switching conf_stat to 10 mid-off-phase → minute digits visible on the next edge; hour digits steady.
- Assert rst asynchronously mid-cycle while digit 4 is active → digit_sel=0, seg=0 before the next clk edge; after release, scan restarts at digit 0.
- ACTIVE_LOW=1 rerun of the first scenario → all output bits inverted; reset levels are all 1s.
